// File: rtl/router_pkg.sv
// Shared definitions for the router output path: header layout, port codes, defaults.
package router_pkg;

   localparam int WIDTH_DEF   = 8;
   localparam int DEPTH_DEF   = 16;
   localparam int TIMEOUT_DEF = 30;

   // Header byte layout: destination in [1:0], payload length in [7:2]
   localparam int ADDR_LSB = 0;
   localparam int ADDR_MSB = 1;
   localparam int LEN_LSB  = 2;
   localparam int LEN_MSB  = 7;
   localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;
   localparam int PKT_W    = LEN_W + 1;

   typedef enum logic [1:0] {
      PORT_0 = 2'd0,
      PORT_1 = 2'd1,
      PORT_2 = 2'd2
   } port_addr_e;

   // Bytes still to come after a header: payload plus one parity byte
   function automatic logic [PKT_W-1:0] hdr_remaining(input logic [7:0] hdr);
      return {1'b0, hdr[LEN_MSB:LEN_LSB]} + PKT_W'(1);
   endfunction

endpackage

// File: rtl/router_timeout_ctr.sv
// Idle watchdog: counts cycles with data waiting and no read, fires a flush after TIMEOUT.
// Latency: flush is combinational on the last idle cycle; soft_reset follows one edge later.
// Backpressure: none; any read or an empty FIFO restarts the count.
module router_timeout_ctr
   import router_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic valid,
   input  logic read_enable,
   output logic flush,
   output logic soft_reset
);

   localparam int TW = $clog2(TIMEOUT) + 1;

   logic [TW-1:0] tcnt;
   logic          idle;

   assign idle  = valid && !read_enable;
   assign flush = idle && (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcnt       <= '0;
         soft_reset <= 1'b0;
      end else begin
         soft_reset <= flush;
         if (!idle || flush)
            tcnt <= '0;
         else
            tcnt <= tcnt + TW'(1);
      end
   end

endmodule

// File: rtl/router_port_fifo.sv
// Per-port output buffer with packet tracking and idle-timeout self flush.
// Latency: data_out is registered, one cycle after a read_enable on a non-empty FIFO.
// Backpressure: writes are dropped while full (full sampled before a same-cycle read).
module router_port_fifo
   import router_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write_enable,
   input  logic             header_flag,
   input  logic [WIDTH-1:0] data_in,
   input  logic             read_enable,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             full,
   output logic             empty,
   output logic             soft_reset
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [WIDTH:0]     mem [DEPTH];
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic [PKT_W-1:0]   pkt_cnt;
   logic               pkt_end;
   logic [WIDTH:0]     rd_ent;
   logic               push;
   logic               pop;
   logic               flush;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign valid_out = !empty;
   assign push      = write_enable && !full && !flush;
   assign pop       = read_enable && !empty;
   assign rd_ent    = mem[rd_ptr[AW-1:0]];

   router_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk         (clk),
      .reset       (reset),
      .valid       (valid_out),
      .read_enable (read_enable),
      .flush       (flush),
      .soft_reset  (soft_reset)
   );

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= {header_flag, data_in};
   end

   // pkt_end marks the cycle right after the parity byte left, so the line can idle at 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pkt_cnt  <= '0;
         pkt_end  <= 1'b0;
         data_out <= '0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pkt_cnt  <= '0;
         pkt_end  <= 1'b0;
         data_out <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            data_out <= rd_ent[WIDTH-1:0];
            if (rd_ent[WIDTH]) begin
               pkt_cnt <= hdr_remaining(rd_ent[7:0]);
               pkt_end <= 1'b0;
            end else if (pkt_cnt != '0) begin
               pkt_cnt <= pkt_cnt - PKT_W'(1);
               pkt_end <= (pkt_cnt == PKT_W'(1));
            end else begin
               pkt_end <= 1'b0;
            end
         end else begin
            if (pkt_end)
               data_out <= '0;
            pkt_end <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_router_port_fifo.sv
// Directed bench for router_port_fifo with a queue-based reference model checked every cycle.
module tb_router_port_fifo;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 30;

   logic       clk = 1'b0;
   logic       reset;
   logic       write_enable;
   logic       header_flag;
   logic [7:0] data_in;
   logic       read_enable;
   logic [7:0] data_out;
   logic       valid_out;
   logic       full;
   logic       empty;
   logic       soft_reset;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [8:0] q [$];
   logic [7:0] m_dout;
   int         m_rem;
   int         m_idle;
   bit         m_end;
   bit         m_sr;

   always #5 clk = ~clk;

   router_port_fifo #(
      .WIDTH   (8),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .write_enable (write_enable),
      .header_flag  (header_flag),
      .data_in      (data_in),
      .read_enable  (read_enable),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .full         (full),
      .empty        (empty),
      .soft_reset   (soft_reset)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = 8'h00;
      m_rem  = 0;
      m_idle = 0;
      m_end  = 1'b0;
      m_sr   = 1'b0;
   endtask

   // Apply one rising edge to the model using the inputs currently driven
   task automatic model_edge();
      bit         emp;
      bit         ful;
      bit         idle;
      bit         nend;
      logic [8:0] e;
      emp  = (q.size() == 0);
      ful  = (q.size() == DEPTH);
      idle = !emp && !read_enable;
      nend = 1'b0;
      if (idle && m_idle == TIMEOUT - 1) begin
         q.delete();
         m_dout = 8'h00;
         m_rem  = 0;
         m_end  = 1'b0;
         m_idle = 0;
         m_sr   = 1'b1;
         return;
      end
      m_sr   = 1'b0;
      m_idle = idle ? m_idle + 1 : 0;
      if (read_enable && !emp) begin
         e      = q.pop_front();
         m_dout = e[7:0];
         if (e[8]) begin
            m_rem = int'(e[7:2]) + 1;
         end else if (m_rem > 0) begin
            m_rem--;
            nend = (m_rem == 0);
         end
      end else if (m_end) begin
         m_dout = 8'h00;
      end
      m_end = nend;
      if (write_enable && !ful)
         q.push_back({header_flag, data_in});
   endtask

   task automatic step(input bit we, input bit hf, input logic [7:0] d, input bit re);
      write_enable = we;
      header_flag  = hf;
      data_in      = d;
      read_enable  = re;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   always @(negedge clk) begin
      check("data_out",   32'(data_out),   32'(m_dout));
      check("valid_out",  32'(valid_out),  32'(q.size() != 0));
      check("full",       32'(full),       32'(q.size() == DEPTH));
      check("empty",      32'(empty),      32'(q.size() == 0));
      check("soft_reset", 32'(soft_reset), 32'(m_sr));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pk [5];
      int first;
      int pulses;
      int cnt;

      pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0F};
      write_enable = 1'b0;
      header_flag  = 1'b0;
      data_in      = 8'h00;
      read_enable  = 1'b0;
      reset        = 1'b1;
      model_reset();
      #1;
      check("rst_empty", 32'(empty), 1);
      check("rst_valid", 32'(valid_out), 0);
      check("rst_dout",  32'(data_out), 0);
      check("rst_sr",    32'(soft_reset), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // reset in the middle of a stream
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h60 + 8'(i), 1'b0);
      check("pre_rst_valid", 32'(valid_out), 1);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("midrst_empty", 32'(empty), 1);
      check("midrst_valid", 32'(valid_out), 0);
      check("midrst_dout",  32'(data_out), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      step(1'b1, 1'b0, 8'hA5, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("a5_read", 32'(data_out), 32'hA5);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("read_on_empty_hold", 32'(data_out), 32'hA5);
      check("read_on_empty_empty", 32'(empty), 1);

      // packet pass-through and idle-line zero
      step(1'b1, 1'b1, 8'h0D, 1'b0);
      for (int i = 1; i < 5; i++) step(1'b1, 1'b0, pk[i], 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         check("pkt_byte", 32'(data_out), 32'(pk[i]));
      end
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check("pkt_idle_zero", 32'(data_out), 0);

      // fill and overflow
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 1'b0, 8'(i), 1'b0);
         if (i == 14) check("not_full_15", 32'(full), 0);
         if (i == 15) check("full_16", 32'(full), 1);
      end
      check("full_after_drop", 32'(full), 1);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         check("fill_read", 32'(data_out), 32'(i));
      end
      check("fill_drained_empty", 32'(empty), 1);

      // pointer wrap with concurrent read+write
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h30 + 8'(i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 8'h40 + 8'(i), 1'b1);
         check("wrap_order", 32'(data_out), (i < 8) ? 32'(8'h30 + 8'(i)) : 32'(8'h40 + 8'(i - 8)));
      end
      cnt = 0;
      while (!empty && cnt < 40) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         cnt++;
      end
      check("wrap_occupancy", 32'(cnt), 8);
      check("wrap_last", 32'(data_out), 32'h53);

      // timeout flush
      step(1'b1, 1'b0, 8'h77, 1'b0);
      first = -1;
      pulses = 0;
      for (int k = 1; k <= 40; k++) begin
         step(1'b0, 1'b0, 8'h00, 1'b0);
         if (soft_reset === 1'b1) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      check("timeout_cycle", 32'(first), 30);
      check("timeout_pulses", 32'(pulses), 1);
      check("timeout_empty", 32'(empty), 1);
      check("timeout_dout", 32'(data_out), 0);

      // read at cycle 29 prevents the flush
      step(1'b1, 1'b0, 8'h78, 1'b0);
      pulses = 0;
      for (int k = 1; k <= 29; k++) begin
         step(1'b0, 1'b0, 8'h00, 1'b0);
         if (soft_reset === 1'b1) pulses++;
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
      if (soft_reset === 1'b1) pulses++;
      for (int k = 0; k < 35; k++) begin
         step(1'b0, 1'b0, 8'h00, 1'b0);
         if (soft_reset === 1'b1) pulses++;
      end
      check("no_timeout_pulses", 32'(pulses), 0);
      check("no_timeout_dout", 32'(data_out), 32'h78);

      // write while full with concurrent read
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h50 + 8'(i), 1'b0);
      check("wof_full", 32'(full), 1);
      step(1'b1, 1'b0, 8'hEE, 1'b1);
      check("wof_dout", 32'(data_out), 32'h50);
      check("wof_not_full", 32'(full), 0);
      cnt = 0;
      while (!empty && cnt < 40) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         cnt++;
      end
      check("wof_occupancy", 32'(cnt), 15);
      check("wof_last", 32'(data_out), 32'h5F);

      step(1'b0, 1'b0, 8'h00, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
